// File: rtl/irrigation_cycle_timer_pkg.sv
// Shared types and default timing for the irrigation cycle timer.
package irrigation_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WATER   = 2'd1,
    ST_SOAK    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  localparam int unsigned DEF_WATER_TICKS   = 10;
  localparam int unsigned DEF_SOAK_TICKS    = 5;
  localparam int unsigned DEF_CYCLES        = 3;
  localparam int unsigned DEF_LOCKOUT_TICKS = 20;
  localparam int unsigned DEF_CNT_W         = 8;
  localparam int unsigned CYC_W             = 4;

endpackage

// File: rtl/irrigation_cycle_timer_if.sv
// Control requests and status outputs of the irrigation cycle timer.
interface irrigation_cycle_timer_if;
  import irrigation_pkg::*;

  logic             start;
  logic             inhibit;
  logic             valve_open;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CYC_W-1:0] cycle_num;

  modport master (
    output start, inhibit,
    input  valve_open, busy, done, aborted, cycle_num
  );

  modport slave (
    input  start, inhibit,
    output valve_open, busy, done, aborted, cycle_num
  );
endinterface

// File: rtl/irrigation_cycle_timer_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector; one-cycle pulse per input rise.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise_c
);

  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 3'b000;
    else        sync_q <= sync_d;
  end

  assign rise_c = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/irrigation_cycle_timer.sv
// Watering programme sequencer: water/soak bursts counted in slow-clock ticks, then lockout.
module irrigation_cycle_timer
  import irrigation_pkg::*;
#(
  parameter int unsigned WATER_TICKS   = DEF_WATER_TICKS,
  parameter int unsigned SOAK_TICKS    = DEF_SOAK_TICKS,
  parameter int unsigned CYCLES        = DEF_CYCLES,
  parameter int unsigned LOCKOUT_TICKS = DEF_LOCKOUT_TICKS,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     slow_clk,
  irrigation_cycle_timer_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             valve_q, valve_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;
  logic             tick_c;
  logic             water_exp_c, soak_exp_c, lock_exp_c, last_cyc_c;

  edge_sync u_sync (
    .clk    (clock),
    .rst_n  (reset),
    .d      (slow_clk),
    .rise_c (tick_c)
  );

  assign water_exp_c = tick_c && (cnt_q == CNT_W'(WATER_TICKS - 1));
  assign soak_exp_c  = tick_c && (cnt_q == CNT_W'(SOAK_TICKS - 1));
  assign lock_exp_c  = tick_c && (cnt_q == CNT_W'(LOCKOUT_TICKS - 1));
  assign last_cyc_c  = (cyc_q == CYC_W'(CYCLES - 1));

  // Next state; abort takes priority over a same-cycle expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.inhibit) begin
          state_d = ST_WATER;
          cnt_d   = '0;
          cyc_d   = '0;
        end
      end
      ST_WATER: begin
        if (bus.inhibit) begin
          state_d = ST_LOCKOUT;
          cnt_d   = '0;
          cyc_d   = '0;
          abort_d = 1'b1;
        end else if (water_exp_c) begin
          cnt_d = '0;
          if (last_cyc_c) begin
            state_d = ST_LOCKOUT;
            cyc_d   = '0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SOAK;
          end
        end else if (tick_c) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SOAK: begin
        if (bus.inhibit) begin
          state_d = ST_LOCKOUT;
          cnt_d   = '0;
          cyc_d   = '0;
          abort_d = 1'b1;
        end else if (soak_exp_c) begin
          state_d = ST_WATER;
          cnt_d   = '0;
          cyc_d   = cyc_q + CYC_W'(1);
        end else if (tick_c) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOCKOUT: begin
        if (lock_exp_c) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (tick_c) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        cyc_d   = '0;
      end
    endcase
    valve_d = (state_d == ST_WATER);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cyc_q   <= '0;
      valve_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      valve_q <= valve_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  assign bus.valve_open = valve_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.aborted    = abort_q;
  assign bus.cycle_num  = cyc_q;

endmodule

// File: tb/tb_irrigation_cycle_timer.sv
// Scoreboard bench: stimulus queues expected output changes, a monitor compares each change.
module tb_irrigation_cycle_timer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic slow = 1'b0;
  logic slow_en = 1'b0;
  logic mon_en = 1'b0;
  int   n_pass = 0;
  int   n_chk = 0;
  int   rise_cnt = 0;
  int   tick_cnt = 0;
  int   snap;
  event rise_ev;

  typedef struct {
    logic [7:0] vec;
    int         ticks;
  } exp_t;

  exp_t exp_q[$];

  irrigation_cycle_timer_if bus_if ();

  irrigation_cycle_timer #(
    .WATER_TICKS  (3),
    .SOAK_TICKS   (2),
    .CYCLES       (2),
    .LOCKOUT_TICKS(4),
    .CNT_W        (8)
  ) dut (
    .clock   (clk),
    .reset   (rst_n),
    .slow_clk(slow),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  // Synchronous slow clock, period 8 system clocks, edges 1 time unit after posedge.
  initial begin
    forever begin
      repeat (4) @(posedge clk);
      #1;
      if (slow_en) begin
        slow = ~slow;
        if (slow) begin
          rise_cnt++;
          ->rise_ev;
        end
      end
    end
  end

  function automatic void check(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
  endfunction

  function automatic void push(input logic v, input logic b, input logic [3:0] c,
                               input logic d, input logic a, input int ticks);
    exp_t e;
    e.vec   = {v, b, c, d, a};
    e.ticks = ticks;
    exp_q.push_back(e);
  endfunction

  // Monitor: every change of the output vector consumes one expected entry.
  logic [7:0] prev_vec = 8'h00;
  int         last_rise = 0;
  int         n_evt = 0;
  always @(negedge clk) begin
    logic [7:0] cur;
    exp_t e;
    cur = {bus_if.valve_open, bus_if.busy, bus_if.cycle_num, bus_if.done, bus_if.aborted};
    if (dut.u_sync.rise_c) tick_cnt++;
    if (!mon_en) begin
      prev_vec  = 8'h00;
      last_rise = rise_cnt;
    end else if (cur != prev_vec) begin
      n_evt++;
      if (exp_q.size() == 0) begin
        check($sformatf("unexpected_change_%0d", n_evt), int'(cur), int'(prev_vec));
      end else begin
        e = exp_q.pop_front();
        check($sformatf("out_vec_%0d", n_evt), int'(cur), int'(e.vec));
        if (e.ticks >= 0)
          check($sformatf("tick_gap_%0d", n_evt), rise_cnt - last_rise, e.ticks);
      end
      prev_vec  = cur;
      last_rise = rise_cnt;
    end
  end

  task automatic wait_rise_plus(input int n, input int k);
    repeat (n) @(rise_ev);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string nm, input int max_clk);
    for (int i = 0; i < max_clk && exp_q.size() != 0; i++) @(posedge clk);
    check(nm, exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
  endtask

  // Full normal programme after a start: W3, S2, W3, done, lockout 4.
  task automatic push_normal(input int first_ticks);
    push(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, first_ticks);
    push(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 3);
    push(1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 2);
    push(1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 3);
    push(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 0);
    push(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4);
  endtask

  initial begin
    bus_if.start   = 1'b0;
    bus_if.inhibit = 1'b0;
    slow_en        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vec", int'({bus_if.valve_open, bus_if.busy, bus_if.cycle_num,
                           bus_if.done, bus_if.aborted}), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;

    // 1: asynchronous reset mid-WATER
    wait_rise_plus(1, 5);
    push(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, -1);
    pulse_start();
    wait_rise_plus(1, 2);
    check("t1_in_water", int'(bus_if.valve_open), 1);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_rst_valve", int'(bus_if.valve_open), 0);
    check("t1_rst_busy", int'(bus_if.busy), 0);
    check("t1_rst_cyc", int'(bus_if.cycle_num), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t1_idle_busy", int'(bus_if.busy), 0);
    check("t1_queue", exp_q.size(), 0);
    mon_en = 1'b1;

    // 2: normal programme from a one-clock start pulse
    wait_rise_plus(1, 5);
    push_normal(-1);
    pulse_start();
    wait_drain("t2_drain", 400);

    // 3: inhibit during the second WATER burst
    wait_rise_plus(1, 5);
    push(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, -1);
    push(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 3);
    push(1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 2);
    push(1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1);
    push(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 0);
    push(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4);
    pulse_start();
    wait_rise_plus(6, 5);
    bus_if.inhibit = 1'b1;
    @(posedge clk);
    #1;
    check("t3_valve_closed", int'(bus_if.valve_open), 0);
    bus_if.inhibit = 1'b0;
    wait_drain("t3_drain", 400);

    // 4: inhibit on the same clock as the final WATER expiry
    wait_rise_plus(1, 5);
    push(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, -1);
    push(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 3);
    push(1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 2);
    push(1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 3);
    push(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 0);
    push(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4);
    pulse_start();
    wait_rise_plus(8, 2);
    bus_if.inhibit = 1'b1;
    @(posedge clk);
    #1;
    bus_if.inhibit = 1'b0;
    wait_drain("t4_drain", 400);

    // 5: start held under inhibit, then through lockout into a restart
    bus_if.start   = 1'b1;
    bus_if.inhibit = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t5_inh_busy", int'(bus_if.busy), 0);
    check("t5_inh_valve", int'(bus_if.valve_open), 0);
    wait_rise_plus(1, 5);
    push_normal(-1);
    push(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 0);
    push(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 3);
    push(1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 2);
    push(1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 3);
    push(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 0);
    push(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4);
    bus_if.inhibit = 1'b0;
    @(posedge clk);
    #1;
    check("t5_water_next", int'(bus_if.valve_open), 1);
    for (int i = 0; i < 400 && exp_q.size() > 5; i++) @(posedge clk);
    #1;
    check("t5_restart_seen", exp_q.size(), 5);
    bus_if.start = 1'b0;
    wait_drain("t5_drain", 400);

    // 6: static slow clock freezes the programme; async toggling gives one tick per rise
    slow_en = 1'b0;
    @(posedge clk);
    #1;
    slow = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    snap = tick_cnt;
    push(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, -1);
    pulse_start();
    repeat (100) @(posedge clk);
    #1;
    check("t6_static_ticks", tick_cnt - snap, 0);
    check("t6_frozen_valve", int'(bus_if.valve_open), 1);
    push(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, -1);
    push(1'b1, 1'b1, 4'd1, 1'b0, 1'b0, -1);
    push(1'b0, 1'b1, 4'd0, 1'b1, 1'b0, -1);
    push(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, -1);
    push(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, -1);
    snap = tick_cnt;
    for (int i = 0; i < 50; i++) begin
      #41 slow = 1'b0;
      #42 slow = 1'b1;
    end
    repeat (10) @(posedge clk);
    #1;
    check("t6_async_ticks", tick_cnt - snap, 50);
    wait_drain("t6_drain", 400);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
